// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, keyboard command bytes and
// the odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INHIBIT = 4'd1,
        ST_RTS     = 4'd2,
        ST_DATA    = 4'd3,
        ST_STOP    = 4'd4,
        ST_ACK     = 4'd5,
        ST_WAITREL = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 parity bit makes the 9-bit {parity, data} word carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status and pad-level signal bundle between a PS/2 host transmitter
// (slave modport) and its user plus pad wrapper (master modport).
interface ps2_host_tx_if;
    logic       wr_en;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output wr_en, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, busy, tx_done, tx_err
    );

    modport slave (
        input  wr_en, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock pad: level changes only after FILTER_LEN
// identical samples; o_fall pulses for one cycle on each accepted 1->0 change.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2c,
    output logic o_level,
    output logic o_fall
);
    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_level;
    logic                  r_fall;
    logic [FILTER_LEN-1:0] w_next;

    assign w_next = {r_shift[FILTER_LEN-2:0], i_ps2c};

    // Sample history, filtered level and one-cycle falling-edge strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_shift <= w_next;
            r_fall  <= 1'b0;
            if (&w_next) begin
                r_level <= 1'b1;
            end else if (~|w_next) begin
                r_level <= 1'b0;
                r_fall  <= r_level;
            end else begin
                r_level <= r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        Reloj,
    input  logic        RST,
    ps2_host_tx_if.slave bus
);
    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1 || FILTER_LEN < 2) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES>=2, TIMEOUT_CYCLES>=1, FILTER_LEN>=2 required");
    end

    ps2_state_e  r_state;
    logic [8:0]  r_sh;
    logic [31:0] r_cnt;
    logic [3:0]  r_n;
    logic        r_ack;
    logic        r_c_oe;
    logic        r_d_oe;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_level;
    logic        w_fall;
    logic        w_wdog_hit;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (Reloj),
        .i_rst   (RST),
        .i_ps2c  (bus.ps2c_in),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_wdog;
    logic        w_wdog_run;

    assign w_wdog_run = (r_state == ST_RTS)  || (r_state == ST_DATA) ||
                        (r_state == ST_STOP) || (r_state == ST_ACK)  ||
                        (r_state == ST_WAITREL);
    assign w_wdog_hit = w_wdog_run && (r_wdog == TO_LAST);

    // Watchdog: restarts at accept, counts only while waiting on the device.
    always_ff @(posedge Reloj) begin
        if (RST) begin
            r_wdog <= 32'd0;
        end else if (r_state == ST_IDLE && bus.wr_en) begin
            r_wdog <= 32'd0;
        end else if (w_wdog_run) begin
            r_wdog <= r_wdog + 32'd1;
        end else begin
            r_wdog <= r_wdog;
        end
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    // Transfer FSM with registered pad enables and status pulses.
    always_ff @(posedge Reloj) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sh    <= 9'd0;
            r_cnt   <= 32'd0;
            r_n     <= 4'd0;
            r_ack   <= 1'b1;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.wr_en) begin
                        r_state <= ST_INHIBIT;
                        r_sh    <= {odd_parity(bus.din), bus.din};
                        r_cnt   <= 32'd0;
                        r_busy  <= 1'b1;
                        r_c_oe  <= 1'b1;
                        r_d_oe  <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    // Start bit goes onto the bus during the final inhibit cycle.
                    if (r_cnt == INH_LAST - 32'd1) begin
                        r_d_oe <= 1'b1;
                    end
                    if (r_cnt == INH_LAST) begin
                        r_state <= ST_RTS;
                        r_c_oe  <= 1'b0;
                    end
                end
                ST_RTS: begin
                    if (w_fall) begin
                        r_state <= ST_DATA;
                        r_n     <= 4'd0;
                        r_d_oe  <= ~r_sh[0];
                    end
                end
                ST_DATA: begin
                    if (w_fall) begin
                        if (r_n == 4'd8) begin
                            r_state <= ST_STOP;
                            r_n     <= 4'd9;
                            r_d_oe  <= 1'b0;
                        end else begin
                            r_sh   <= {1'b0, r_sh[8:1]};
                            r_n    <= r_n + 4'd1;
                            r_d_oe <= ~r_sh[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_fall) begin
                        r_state <= ST_ACK;
                        r_n     <= 4'd10;
                        r_ack   <= bus.ps2d_in;
                    end
                end
                ST_ACK: begin
                    if (!r_ack) begin
                        r_state <= ST_WAITREL;
                    end else begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end
                end
                ST_WAITREL: begin
                    if (w_level && bus.ps2d_in) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_c_oe  <= 1'b0;
                    r_d_oe  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_c_oe  <= 1'b0;
                    r_d_oe  <= 1'b0;
                end
            endcase
            if (w_wdog_hit) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
                r_c_oe  <= 1'b0;
                r_d_oe  <= 1'b0;
            end
        end
    end

    assign bus.ps2c_oe = r_c_oe;
    assign bus.ps2d_oe = r_d_oe;
    assign bus.busy    = r_busy;
    assign bus.tx_done = r_done;
    assign bus.tx_err  = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model that clocks
// the frame, records the bits it samples and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TOUT = 1000;
    localparam int HALF = 30;

    logic clk;
    logic rst;
    logic dev_clk;
    logic dev_dat;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   err_cnt;

    ps2_host_tx_if bus_if ();

    assign bus_if.ps2c_in = dev_clk & ~bus_if.ps2c_oe;
    assign bus_if.ps2d_in = dev_dat & ~bus_if.ps2d_oe;

    ps2_host_tx #(
        .FILTER_LEN     (8),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .Reloj (clk),
        .RST   (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.tx_done) done_cnt++;
        if (bus_if.tx_err)  err_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus_if.wr_en = 1'b1;
        bus_if.din   = d;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        bus_if.din   = 8'h00;
    endtask

    // Device: wait for request-to-send, sample start bit, then clock nclk pulses.
    task automatic dev_run(input int nclk, input logic do_ack, output logic [10:0] bits);
        int guard;
        bits  = '0;
        guard = 0;
        while (!(bus_if.ps2c_oe == 1'b0 && bus_if.ps2d_oe == 1'b1) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("rts_seen", int'(guard < 3000), 1);
        repeat (20) @(negedge clk);
        bits[0] = bus_if.ps2d_in;
        for (int i = 1; i <= nclk; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = bus_if.ps2d_in;
            if (i == 10 && do_ack) dev_dat = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic frame_ok(input string tag, input logic [7:0] d, input int exp_bits);
        logic [10:0] bits;
        int d0;
        d0 = done_cnt;
        send(d);
        check({tag, "_busy"}, int'(bus_if.busy), 1);
        dev_run(11, 1'b1, bits);
        repeat (10) @(negedge clk);
        check({tag, "_bits"}, int'(bits), exp_bits);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_idle"}, int'({bus_if.busy, bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
    endtask

    initial begin
        logic [10:0] bits;
        int d0, e0, n;
        n_checks = 0; n_errors = 0; done_cnt = 0; err_cnt = 0;
        rst = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
        bus_if.wr_en = 1'b0; bus_if.din = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_outputs", int'({bus_if.ps2c_oe, bus_if.ps2d_oe, bus_if.busy,
                                    bus_if.tx_done, bus_if.tx_err}), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Bits listed stop..start: ED -> 1,1,11101101,0 ; FF -> 1,1,11111111,0 ; 01 -> 1,0,00000001,0
        frame_ok("ed", CMD_SET_LED, 32'h7DA);
        frame_ok("ff", CMD_RESET,   32'h7FE);
        frame_ok("01", 8'h01,       32'h402);

        // Missing ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'h55);
        dev_run(11, 1'b0, bits);
        repeat (10) @(negedge clk);
        check("noack_err", err_cnt - e0, 1);
        check("noack_done", done_cnt - d0, 0);
        check("noack_idle", int'({bus_if.busy, bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);

        // Second request while busy is dropped
        d0 = done_cnt;
        send(CMD_SET_LED);
        repeat (50) @(negedge clk);
        send(CMD_ENABLE);
        dev_run(11, 1'b1, bits);
        repeat (10) @(negedge clk);
        check("busy_wr_bits", int'(bits), 32'h7DA);
        check("busy_wr_done", done_cnt - d0, 1);
        repeat (300) @(negedge clk);
        check("busy_wr_quiet", int'({bus_if.busy, bus_if.ps2c_oe}), 0);

        // Reset in the middle of the data bits
        d0 = done_cnt; e0 = err_cnt;
        send(CMD_RESET);
        dev_run(5, 1'b1, bits);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lines", int'({bus_if.ps2c_oe, bus_if.ps2d_oe, bus_if.busy}), 0);
        check("midrst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Device never clocks after request-to-send
        e0 = err_cnt;
        send(8'h01);
        n = 1;
`ifdef PS2_TX_TIMEOUT_EN
        while (!bus_if.tx_err && n < INH + TOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("tout_window", int'(n >= INH + TOUT - 2 && n <= INH + TOUT + 2), 1);
        @(negedge clk);
        check("tout_idle", int'({bus_if.busy, bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
`else
        repeat (10000) @(negedge clk);
        check("nowdog_busy", int'(bus_if.busy), 1);
        check("nowdog_noerr", err_cnt - e0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
